// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU word types and fetch FSM state encoding
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    localparam word_t PC_STEP = 32'd4;

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with load, valid-clear and hold
module if_id_reg
    import cpu_types_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [WORD_W-1:0] instr_i,
    input  logic [WORD_W-1:0] npc_i,
    output logic [WORD_W-1:0] instr_o,
    output logic [WORD_W-1:0] npc_o,
    output logic              valid_o
);

    word_t instr_q;
    word_t npc_q;
    logic  valid_q;

    // Clear only drops valid; the stale payload is kept so squashes never
    // cause a partial update of the register contents.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            instr_q <= '0;
            npc_q   <= '0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            instr_q <= instr_i;
            npc_q   <= npc_i;
            valid_q <= 1'b1;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end
    end

    assign instr_o = instr_q;
    assign npc_o   = npc_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch FSM with one-entry skid buffer feeding IF/ID
module fetch_unit
    import cpu_types_pkg::*;
(
    input  logic              CLK,
    input  logic              nRST,
    input  logic [WORD_W-1:0] pc_addr,
    output logic              pcEN,
    output logic              imemREN,
    output logic [WORD_W-1:0] imemaddr,
    input  logic              ihit,
    input  logic [WORD_W-1:0] imemload,
    input  logic              id_stall,
    input  logic              flush,
    input  logic              halt,
    output logic [WORD_W-1:0] instr_id,
    output logic [WORD_W-1:0] npc_id,
    output logic              valid_id
);

    fetch_state_t state_q, state_d;
    word_t        skid_instr_q, skid_instr_d;
    word_t        skid_npc_q, skid_npc_d;
    word_t        npc;
    word_t        load_instr, load_npc;
    logic         pc_en, mem_ren, load, clear;

    assign npc      = pc_addr + PC_STEP;
    assign imemaddr = pc_addr;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= FETCH;
            skid_instr_q <= '0;
            skid_npc_q   <= '0;
        end else begin
            state_q      <= state_d;
            skid_instr_q <= skid_instr_d;
            skid_npc_q   <= skid_npc_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        skid_instr_d = skid_instr_q;
        skid_npc_d   = skid_npc_q;
        pc_en        = 1'b0;
        mem_ren      = 1'b0;
        load         = 1'b0;
        clear        = 1'b0;
        load_instr   = imemload;
        load_npc     = npc;
        case (state_q)
            FETCH: begin
                mem_ren = 1'b1;
                if (flush) begin
                    pc_en = 1'b1;
                    clear = 1'b1;
                end else if (halt) begin
                    // PC is frozen in the halt cycle; a coincident hit is dropped.
                    clear   = 1'b1;
                    state_d = HALTED;
                end else if (ihit) begin
                    pc_en = 1'b1;
                    if (id_stall && valid_id) begin
                        skid_instr_d = imemload;
                        skid_npc_d   = npc;
                        state_d      = HOLD;
                    end else begin
                        load = 1'b1;
                    end
                end else if (!id_stall) begin
                    clear = 1'b1;
                end
            end
            HOLD: begin
                if (flush) begin
                    pc_en   = 1'b1;
                    clear   = 1'b1;
                    state_d = FETCH;
                end else if (halt) begin
                    clear   = 1'b1;
                    state_d = HALTED;
                end else if (!id_stall) begin
                    load       = 1'b1;
                    load_instr = skid_instr_q;
                    load_npc   = skid_npc_q;
                    state_d    = FETCH;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // Strobes are gated by reset so they drop the instant nRST falls.
    assign pcEN    = nRST & pc_en;
    assign imemREN = nRST & mem_ren;

    if_id_reg u_if_id_reg (
        .clk_i   (CLK),
        .rst_ni  (nRST),
        .load_i  (load),
        .clear_i (clear),
        .instr_i (load_instr),
        .npc_i   (load_npc),
        .instr_o (instr_id),
        .npc_o   (npc_id),
        .valid_o (valid_id)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

    logic        CLK;
    logic        nRST;
    logic [31:0] pc_addr;
    logic        pcEN;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        id_stall;
    logic        flush;
    logic        halt;
    logic [31:0] instr_id;
    logic [31:0] npc_id;
    logic        valid_id;

    int checks   = 0;
    int failures = 0;

    fetch_unit dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .pc_addr  (pc_addr),
        .pcEN     (pcEN),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .ihit     (ihit),
        .imemload (imemload),
        .id_stall (id_stall),
        .flush    (flush),
        .halt     (halt),
        .instr_id (instr_id),
        .npc_id   (npc_id),
        .valid_id (valid_id)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic hit, input logic [31:0] word, input logic [31:0] pc,
                         input logic stall, input logic fl, input logic hl);
        ihit     = hit;
        imemload = word;
        pc_addr  = pc;
        id_stall = stall;
        flush    = fl;
        halt     = hl;
        #1;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        nRST = 1'b0;
        drive(1'b1, 32'hAAAA_AAAA, 32'h0, 1'b0, 1'b0, 1'b0);
        #2;
        check("rst_instr", instr_id, 32'h0);
        check("rst_npc", npc_id, 32'h0);
        check("rst_valid", {31'b0, valid_id}, 32'h0);
        check("rst_pcen", {31'b0, pcEN}, 32'h0);

        @(posedge CLK);
        #2;
        nRST = 1'b1;
        drive(1'b1, 32'h8C01_0004, 32'h0, 1'b0, 1'b0, 1'b0);
        check("first_ren", {31'b0, imemREN}, 32'h1);
        check("first_pcen", {31'b0, pcEN}, 32'h1);
        check("imemaddr", imemaddr, 32'h0);
        tick();
        check("first_instr", instr_id, 32'h8C01_0004);
        check("first_npc", npc_id, 32'h4);
        check("first_valid", {31'b0, valid_id}, 32'h1);

        drive(1'b1, 32'h2002_0001, 32'h8, 1'b1, 1'b0, 1'b0);
        check("skid_pcen", {31'b0, pcEN}, 32'h1);
        tick();
        drive(1'b0, 32'h0, 32'hC, 1'b1, 1'b0, 1'b0);
        check("hold_instr", instr_id, 32'h8C01_0004);
        check("hold_npc", npc_id, 32'h4);
        check("hold_ren", {31'b0, imemREN}, 32'h0);
        check("hold_pcen", {31'b0, pcEN}, 32'h0);
        tick();
        check("hold2_instr", instr_id, 32'h8C01_0004);
        drive(1'b0, 32'h0, 32'hC, 1'b0, 1'b0, 1'b0);
        tick();
        check("drain_instr", instr_id, 32'h2002_0001);
        check("drain_npc", npc_id, 32'hC);
        check("drain_valid", {31'b0, valid_id}, 32'h1);
        check("drain_ren", {31'b0, imemREN}, 32'h1);

        check("miss_pcen", {31'b0, pcEN}, 32'h0);
        tick();
        check("bubble_valid", {31'b0, valid_id}, 32'h0);

        drive(1'b1, 32'hDEAD_BEEF, 32'h10, 1'b0, 1'b1, 1'b0);
        check("flush_pcen", {31'b0, pcEN}, 32'h1);
        tick();
        check("flush_valid", {31'b0, valid_id}, 32'h0);
        check("flush_drop", instr_id, 32'h2002_0001);

        drive(1'b1, 32'h1111_1111, 32'h20, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h2222_2222, 32'h24, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h28, 1'b1, 1'b1, 1'b0);
        check("hflush_pcen", {31'b0, pcEN}, 32'h1);
        tick();
        drive(1'b0, 32'h0, 32'h28, 1'b0, 1'b0, 1'b0);
        check("hflush_valid", {31'b0, valid_id}, 32'h0);
        check("hflush_ren", {31'b0, imemREN}, 32'h1);
        tick();
        check("hflush_discard_v", {31'b0, valid_id}, 32'h0);
        check("hflush_discard_i", instr_id, 32'h1111_1111);

        drive(1'b1, 32'h3333_3333, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0);
        tick();
        check("wrap_instr", instr_id, 32'h3333_3333);
        check("wrap_npc", npc_id, 32'h0);

        drive(1'b0, 32'h0, 32'h30, 1'b0, 1'b1, 1'b1);
        check("fh_pcen", {31'b0, pcEN}, 32'h1);
        tick();
        check("fh_ren", {31'b0, imemREN}, 32'h1);
        check("fh_valid", {31'b0, valid_id}, 32'h0);

        drive(1'b1, 32'h4444_4444, 32'h40, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h5555_5555, 32'h44, 1'b0, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 10; i++) begin
            drive(i[0], 32'h6000_0000 + i, 32'h48 + 4 * i, i[1], ~i[0], 1'b0);
            check("halted_ren", {31'b0, imemREN}, 32'h0);
            check("halted_pcen", {31'b0, pcEN}, 32'h0);
            tick();
            check("halted_valid", {31'b0, valid_id}, 32'h0);
        end
        check("halted_instr", instr_id, 32'h4444_4444);

        #3;
        nRST = 1'b0;
        #1;
        nRST = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("recover_ren", {31'b0, imemREN}, 32'h1);
        check("recover_instr", instr_id, 32'h0);

        tick();
        drive(1'b1, 32'h6666_6666, 32'h50, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h7777_7777, 32'h54, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h0, 32'h58, 1'b1, 1'b1, 1'b0);
        #2;
        nRST = 1'b0;
        #1;
        check("midrst_instr", instr_id, 32'h0);
        check("midrst_npc", npc_id, 32'h0);
        check("midrst_valid", {31'b0, valid_id}, 32'h0);
        check("midrst_pcen", {31'b0, pcEN}, 32'h0);
        #1;
        nRST = 1'b1;
        drive(1'b0, 32'h0, 32'h58, 1'b0, 1'b0, 1'b0);
        tick();
        check("midrst_discard", {31'b0, valid_id}, 32'h0);
        check("midrst_discard_i", instr_id, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
